// File: rtl/l1tlb_req_scheduler.sv
// rtl/l1tlb_req_scheduler.sv - buffered, credit-limited i-TLB/d-TLB miss scheduler toward the L2 TLB
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   flush_i                drops every queued, not yet issued request
//   itlb_req_*             i-TLB miss request (valid / vpn / rdy)
//   dtlb_req_*             d-TLB miss request (valid / vpn / rdy)
//   l2_req_*               single request port to the L2 TLB (valid / vpn / origin / rdy)
//   ans_fire_i             one L2 answer delivered this cycle
//   outstanding_o          requests accepted by the L2 TLB but not yet answered
//   idle_o                 both FIFOs empty and nothing in flight

module l1tlb_req_scheduler #(
    parameter int VPN_W   = 27,
    parameter int QDEPTH  = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           itlb_req_valid_i,
    input  logic [VPN_W-1:0]               itlb_req_vpn_i,
    output logic                           itlb_req_rdy_o,
    input  logic                           dtlb_req_valid_i,
    input  logic [VPN_W-1:0]               dtlb_req_vpn_i,
    output logic                           dtlb_req_rdy_o,
    output logic                           l2_req_valid_o,
    output logic [VPN_W-1:0]               l2_req_vpn_o,
    output logic                           l2_req_origin_o,
    input  logic                           l2_req_rdy_i,
    input  logic                           ans_fire_i,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding_o,
    output logic                           idle_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);
    localparam logic [OW-1:0] CNT_ONE = OW'(1);
    localparam logic [OW-1:0] CNT_MAX = OW'(MAX_OUT);

    // Index 0 = i-TLB, index 1 = d-TLB; matches the l2_req_origin_o encoding.
    logic [VPN_W-1:0] mem_q [2][QDEPTH];
    logic [PW:0]      wr_q  [2];
    logic [PW:0]      rd_q  [2];
    logic [OW-1:0]    outstanding_q;
    logic             tie_q;
    logic             lock_q;
    logic             lock_sel_q;

    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       rdy;
    logic [1:0]       push;
    logic [1:0]       req_valid;
    logic [VPN_W-1:0] req_vpn [2];
    logic [VPN_W-1:0] head    [2];
    logic             sel;
    logic             can_issue;
    logic             valid;
    logic             fire;
    logic             ans_dec;

    assign req_valid  = {dtlb_req_valid_i, itlb_req_valid_i};
    assign req_vpn[0] = itlb_req_vpn_i;
    assign req_vpn[1] = dtlb_req_vpn_i;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            empty[s] = (wr_q[s] == rd_q[s]);
            full[s]  = (wr_q[s][PW] != rd_q[s][PW]) && (wr_q[s][PW-1:0] == rd_q[s][PW-1:0]);
            head[s]  = mem_q[s][rd_q[s][PW-1:0]];
            // rdy uses pre-pop fullness: a full FIFO never accepts, even while popping.
            rdy[s]   = !full[s] && !flush_i;
            push[s]  = req_valid[s] && rdy[s];
        end
    end

    // A presented but unaccepted request keeps its source (lock), so the
    // L2 port sees stable valid/vpn/origin until it is taken or flushed.
    always_comb begin
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (!empty[0] && !empty[1]) begin
            sel = tie_q;
        end else begin
            sel = !empty[1];
        end
    end

    assign can_issue = (outstanding_q < CNT_MAX);
    assign valid     = can_issue && !empty[sel] && !flush_i;
    assign fire      = valid && l2_req_rdy_i;
    // An answer with nothing in flight is a protocol error; the counter saturates.
    assign ans_dec   = ans_fire_i && (outstanding_q != '0);

    assign itlb_req_rdy_o  = rdy[0];
    assign dtlb_req_rdy_o  = rdy[1];
    assign l2_req_valid_o  = valid;
    assign l2_req_vpn_o    = valid ? head[sel] : '0;
    assign l2_req_origin_o = valid && sel;
    assign outstanding_o   = outstanding_q;
    assign idle_o          = empty[0] && empty[1] && (outstanding_q == '0);

    // Storage is not reset: entries are only ever read between valid pointers.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_q[s][wr_q[s][PW-1:0]] <= req_vpn[s];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q          <= '{default: '0};
            rd_q          <= '{default: '0};
            outstanding_q <= '0;
            tie_q         <= 1'b0;
            lock_q        <= 1'b0;
            lock_sel_q    <= 1'b0;
        end else begin
            if (flush_i) begin
                // Issued requests still get answered, so outstanding_q survives a flush.
                wr_q   <= '{default: '0};
                rd_q   <= '{default: '0};
                tie_q  <= 1'b0;
                lock_q <= 1'b0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s]) begin
                        wr_q[s] <= wr_q[s] + PTR_ONE;
                    end
                end
                if (fire) begin
                    rd_q[sel] <= rd_q[sel] + PTR_ONE;
                    lock_q    <= 1'b0;
                    if (!empty[0] && !empty[1]) begin
                        tie_q <= !sel;
                    end
                end else if (valid) begin
                    lock_q     <= 1'b1;
                    lock_sel_q <= sel;
                end
            end

            if (fire && !ans_dec) begin
                outstanding_q <= outstanding_q + CNT_ONE;
            end else if (ans_dec && !fire) begin
                outstanding_q <= outstanding_q - CNT_ONE;
            end
        end
    end

    a_no_ans_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ans_fire_i && (outstanding_q == '0)));

endmodule
